// File: rtl/axis_frame_fifo.sv
// ---------------------------------------------------------------------------
// axis_frame_fifo
//   AXI-Stream FIFO that sits behind the 2:1 stream mux. It buffers 8-bit
//   beats with their TLAST marker, back-pressures the mux via s_tready and
//   reports how many complete frames and how many beats it holds.
//
//   Optional feature macro: FRAME_MODE_EN
//     defined   : store-and-forward. Output is held until a whole frame (a
//                 TLAST beat) is buffered, or the FIFO is full (forced release).
//                 Once a released frame starts draining, it streams to TLAST.
//     undefined : cut-through. Output is valid whenever the FIFO is non-empty.
//
// Ports
//   clk, reset                   single clock, synchronous active-high reset
//   s_tdata/s_tvalid/s_tlast     input beat from the mux
//   s_tready                     FIFO can accept a beat
//   m_tdata/m_tvalid/m_tlast     output beat (first-word fall-through)
//   m_tready                     consumer accepts the beat
//   frame_cnt                    stored TLAST beats currently held
//   level                        beats currently held, 0..DEPTH
// ---------------------------------------------------------------------------
module axis_frame_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  level
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [DATA_W:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [PTR_W-1:0]   fill;
  logic [DATA_W:0]    head;
  logic               empty, full, avail, wr_en, rd_en;

`ifdef FRAME_MODE_EN
  typedef enum logic {ST_HOLD, ST_STREAM} state_e;
  state_e state_q, state_d;
`endif

  always_comb begin
    fill  = wr_ptr_q - rd_ptr_q;
    empty = (fill == '0);
    full  = (fill == PTR_W'(DEPTH));
    head  = mem_q[rd_ptr_q[ADDR_W-1:0]];

`ifdef FRAME_MODE_EN
    // ST_STREAM keeps a started frame flowing even after the forced-release
    // full condition goes away, so long frames cannot deadlock.
    avail = !empty && ((frame_cnt_q != '0) || full || (state_q == ST_STREAM));
`else
    avail = !empty;
`endif

    s_tready  = !full && !reset;
    m_tvalid  = avail && !reset;
    m_tdata   = m_tvalid ? head[DATA_W-1:0] : '0;
    m_tlast   = m_tvalid && head[DATA_W];
    frame_cnt = frame_cnt_q;
    level     = CNT_W'(fill);

    wr_en = s_tvalid && s_tready;
    rd_en = m_tvalid && m_tready;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    frame_cnt_d = frame_cnt_q;
    case ({wr_en && s_tlast, rd_en && m_tlast})
      2'b10:   frame_cnt_d = frame_cnt_q + CNT_W'(1);
      2'b01:   frame_cnt_d = frame_cnt_q - CNT_W'(1);
      default: frame_cnt_d = frame_cnt_q;
    endcase

`ifdef FRAME_MODE_EN
    state_d = state_q;
    if (rd_en) state_d = m_tlast ? ST_HOLD : ST_STREAM;
`endif
  end

  // Storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= {s_tlast, s_tdata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_cnt_q <= '0;
`ifdef FRAME_MODE_EN
      state_q     <= ST_HOLD;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef FRAME_MODE_EN
      state_q     <= state_d;
`endif
    end
  end

endmodule

// File: tb/tb_axis_frame_fifo.sv
module tb_axis_frame_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tlast;
  logic       m_tready = 1'b0;
  logic [4:0] frame_cnt;
  logic [4:0] level;

  int checks = 0;
  int errors = 0;
  logic [8:0] got [$];

  axis_frame_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .frame_cnt(frame_cnt), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] sd;
    logic       sv;
    logic       sl;
    logic       mr;
    logic       ex_sr;
    logic       ex_mv;
    logic [7:0] ex_md;
    logic       ex_ml;
    logic [4:0] ex_fc;
    logic [4:0] ex_lv;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Leaves the bench just after a falling edge with reset released.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs a fixed number of cycles, recording every accepted output beat and
  // dropping s_tvalid once the pending input beat has been taken.
  task automatic collect(input int cycles);
    logic acc;
    for (int c = 0; c < cycles; c++) begin
      #1;
      if (m_tvalid && m_tready) got.push_back({m_tlast, m_tdata});
      acc = s_tvalid && s_tready;
      @(posedge clk);
      #1;
      if (acc) s_tvalid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic put(input logic [7:0] d, input logic l);
    @(negedge clk);
    s_tdata = d; s_tvalid = 1'b1; s_tlast = l;
  endtask

  initial begin
    // rst  sd     sv   sl   mr    sr   mv   md     ml   fc  lv
    tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 5'd0};
    tbl[1]  = '{1'b0, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 5'd0};
    tbl[2]  = '{1'b0, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 5'd0, 5'd1};
    tbl[3]  = '{1'b0, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 5'd0, 5'd1};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1, 5'd1, 5'd1};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 5'd0};
    tbl[6]  = '{1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 5'd0};
    tbl[7]  = '{1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 5'd0};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 5'd1, 5'd1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 5'd1, 5'd1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 5'd1, 5'd1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 5'd0};

    do_reset();
    reset = 1'b1;

`ifndef FRAME_MODE_EN
    // Cut-through frame 22/33/44 with per-cycle status, then a held beat.
    for (int i = 0; i < 12; i++) begin
      reset = tbl[i].rst; s_tdata = tbl[i].sd; s_tvalid = tbl[i].sv;
      s_tlast = tbl[i].sl; m_tready = tbl[i].mr;
      #1;
      chk($sformatf("vec%0d", i),
          {11'd0, s_tready, m_tvalid, m_tdata, m_tlast, frame_cnt, level},
          {11'd0, tbl[i].ex_sr, tbl[i].ex_mv, tbl[i].ex_md, tbl[i].ex_ml, tbl[i].ex_fc, tbl[i].ex_lv});
      @(negedge clk);
    end
`else
    #1;
    chk("rst_gate", {s_tready, m_tvalid, m_tdata, m_tlast}, 11'd0);
`endif

    // Fill to full with a 17th beat held upstream, then drain everything.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      s_tdata = 8'(i); s_tvalid = 1'b1; s_tlast = 1'b0;
      #1;
      chk($sformatf("t2_ready%0d", i), s_tready, 1'b1);
      @(negedge clk);
    end
    s_tdata = 8'h10; s_tvalid = 1'b1;
    #1;
    chk("t2_level_full", level, 5'd16);
    chk("t2_ready_full", s_tready, 1'b0);
    chk("t2_fc_full", frame_cnt, 5'd0);
    m_tready = 1'b1;
    #1;
    // Read happens this cycle but the write must still be refused.
    chk("t2_ready_rd_full", s_tready, 1'b0);
    got.delete();
    collect(22);
    chk("t2_count", got.size(), 17);
    for (int i = 0; i < 17 && i < got.size(); i++)
      chk($sformatf("t2_beat%0d", i), got[i], 9'(i));
    #1;
    chk("t2_level_end", level, 5'd0);

    // Simultaneous TLAST write and TLAST read at frame_cnt=2.
    do_reset();
    put(8'hB0, 1'b0);
    put(8'hB1, 1'b1);
    put(8'hC0, 1'b1);
    @(negedge clk);
    s_tvalid = 1'b0; m_tready = 1'b1;
    @(negedge clk);
    m_tready = 1'b0;
    #1;
    chk("t3_fc_pre", frame_cnt, 5'd2);
    chk("t3_lv_pre", level, 5'd2);
    s_tdata = 8'hD0; s_tvalid = 1'b1; s_tlast = 1'b1; m_tready = 1'b1;
    #1;
    chk("t3_head", {m_tvalid, m_tlast, m_tdata}, {2'b11, 8'hB1});
    @(negedge clk);
    s_tvalid = 1'b0; m_tready = 1'b0;
    #1;
    chk("t3_fc_post", frame_cnt, 5'd2);
    chk("t3_lv_post", level, 5'd2);
    chk("t3_next", m_tdata, 8'hC0);

    // Reset mid-frame discards the buffered beats.
    do_reset();
    put(8'h61, 1'b0);
    put(8'h62, 1'b0);
    @(negedge clk);
    reset = 1'b1; s_tdata = 8'h63; s_tvalid = 1'b1; s_tlast = 1'b0;
    #1;
    chk("t6_rst_out", {s_tready, m_tvalid, m_tdata, m_tlast}, 11'd0);
    @(negedge clk);
    reset = 1'b0; s_tvalid = 1'b0;
    #1;
    chk("t6_after", {s_tready, m_tvalid, frame_cnt, level}, {2'b10, 5'd0, 5'd0});
    put(8'h63, 1'b0);
    put(8'h64, 1'b1);
    @(negedge clk);
    s_tvalid = 1'b0; m_tready = 1'b1;
    got.delete();
    collect(5);
    chk("t6_count", got.size(), 2);
    if (got.size() >= 2) begin
      chk("t6_beat0", got[0], {1'b0, 8'h63});
      chk("t6_beat1", got[1], {1'b1, 8'h64});
    end

`ifdef FRAME_MODE_EN
    // Store-and-forward: nothing leaves until TLAST arrives.
    do_reset();
    m_tready = 1'b1;
    s_tdata = 8'hA1; s_tvalid = 1'b1; s_tlast = 1'b0;
    #1; chk("t4_mv0", m_tvalid, 1'b0);
    @(negedge clk);
    s_tdata = 8'hA2;
    #1; chk("t4_mv1", m_tvalid, 1'b0);
    @(negedge clk);
    s_tdata = 8'hA3; s_tlast = 1'b1;
    #1; chk("t4_mv2", m_tvalid, 1'b0);
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    #1; chk("t4_out0", {m_tvalid, m_tlast, m_tdata}, {2'b10, 8'hA1});
    @(negedge clk);
    #1; chk("t4_out1", {m_tvalid, m_tlast, m_tdata}, {2'b10, 8'hA2});
    @(negedge clk);
    #1; chk("t4_out2", {m_tvalid, m_tlast, m_tdata}, {2'b11, 8'hA3});
    @(negedge clk);
    #1; chk("t4_idle", {m_tvalid, frame_cnt, level}, 11'd0);

    // Forced release on a full FIFO with no TLAST.
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_tdata = 8'(8'h80 + i); s_tvalid = 1'b1; s_tlast = 1'b0;
      #1;
      chk($sformatf("t5_hold%0d", i), m_tvalid, 1'b0);
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    #1;
    chk("t5_release", {m_tvalid, level}, {1'b1, 5'd16});
    got.delete();
    collect(20);
    chk("t5_count", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      chk($sformatf("t5_beat%0d", i), got[i], {1'b0, 8'(8'h80 + i)});
    #1;
    chk("t5_level_end", level, 5'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
